// File: rtl/sqrt_batch_sequencer.sv
// Batch sequencer: walks a block of RAM words, runs each one through the sqrt unit,
// and writes the zero-extended root back at a fixed address offset.
module sqrt_batch_sequencer #(
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned RW      = 4,
    parameter int unsigned RES_OFS = 8,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic          CLK,
    input  logic          ResetN,
    input  logic          go,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_cnt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   proc_cnt,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          sqrt_st,
    output logic [DW-1:0] sqrt_n,
    input  logic          sqrt_done,
    input  logic [RW-1:0] sqrt_root
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 8;
    localparam logic [CW-1:0] MAX_CNT = CW'(1 << AW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_ST,
        S_WT,
        S_WR,
        S_NX,
        S_FIN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CW-1:0] proc_cnt_q, proc_cnt_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          sqrt_st_q, sqrt_st_d;
    logic [DW-1:0] sqrt_n_q, sqrt_n_d;

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            tmo_q       <= '0;
            proc_cnt_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            sqrt_st_q   <= 1'b0;
            sqrt_n_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            proc_cnt_q  <= proc_cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            sqrt_st_q   <= sqrt_st_d;
            sqrt_n_q    <= sqrt_n_d;
        end
    end

    // Outputs are computed for the state being entered, so each one is a flop that
    // lines up with the state register; abort simply never enters WR/ST.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        tmo_d       = tmo_q;
        proc_cnt_d  = proc_cnt_q;
        err_d       = err_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        sqrt_st_d   = 1'b0;
        sqrt_n_d    = sqrt_n_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        cur_d      = base_addr;
                        rem_d      = (word_cnt > MAX_CNT) ? MAX_CNT : word_cnt;
                        proc_cnt_d = '0;
                        err_d      = 1'b0;
                        if (rem_d == '0) begin
                            state_d = S_FIN;
                        end else begin
                            state_d    = S_RD;
                            ram_addr_d = base_addr;
                        end
                    end
                end
                S_RD: state_d = S_CAP;
                S_CAP: begin
                    sqrt_n_d  = ram_rdata;
                    sqrt_st_d = 1'b1;
                    state_d   = S_ST;
                end
                S_ST: begin
                    tmo_d   = '0;
                    state_d = S_WT;
                end
                S_WT: begin
                    if (sqrt_done) begin
                        ram_wdata_d = DW'(sqrt_root);
                        ram_we_d    = 1'b1;
                        ram_addr_d  = cur_q + AW'(RES_OFS);
                        state_d     = S_WR;
                    end else if (tmo_q == TW'(TIMEOUT)) begin
                        ram_wdata_d = {DW{1'b1}};
                        err_d       = 1'b1;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = cur_q + AW'(RES_OFS);
                        state_d     = S_WR;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_WR: state_d = S_NX;
                S_NX: begin
                    proc_cnt_d = proc_cnt_q + CW'(1);
                    cur_d      = cur_q + AW'(1);
                    rem_d      = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d    = S_RD;
                        ram_addr_d = cur_q + AW'(1);
                    end
                end
                S_FIN: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign proc_cnt  = proc_cnt_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign sqrt_st   = sqrt_st_q;
    assign sqrt_n    = sqrt_n_q;

endmodule

// File: tb/tb_sqrt_batch_sequencer.sv
// Directed bench for sqrt_batch_sequencer with a sync-read RAM and a behavioural sqrt unit.
module tb_sqrt_batch_sequencer;

    logic       CLK = 1'b0;
    logic       ResetN;
    logic       go, abort;
    logic [3:0] base_addr;
    logic [4:0] word_cnt;
    logic       busy, done, err;
    logic [4:0] proc_cnt;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       sqrt_st;
    logic [7:0] sqrt_n;
    logic       sq_done = 1'b0;
    logic [3:0] sq_root = 4'd0;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    sqrt_batch_sequencer dut (
        .CLK       (CLK),
        .ResetN    (ResetN),
        .go        (go),
        .abort     (abort),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .proc_cnt  (proc_cnt),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sqrt_st   (sqrt_st),
        .sqrt_n    (sqrt_n),
        .sqrt_done (sq_done),
        .sqrt_root (sq_root)
    );

    // RAM with a side port so the bench can preload words between batches
    logic [7:0] mem [16];
    logic       tb_we = 1'b0;
    logic [3:0] tb_addr = 4'd0;
    logic [7:0] tb_wdata = 8'd0;
    logic [3:0] rd_addr_q = 4'd0;

    always @(posedge CLK) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        rd_addr_q <= ram_addr;
    end

    function automatic logic [3:0] isqrt(input logic [7:0] n);
        for (int r = 15; r >= 0; r--) begin
            if (r * r <= int'(n)) return 4'(r);
        end
        return 4'd0;
    endfunction

    // Sqrt unit: Done drops after St and rises lat+1 cycles into WT unless stuck
    int   lat = 2;
    logic stuck = 1'b0;
    int   sq_cnt = 0;

    always @(posedge CLK) begin
        if (sqrt_st) begin
            sq_done <= 1'b0;
            sq_cnt  <= lat;
            sq_root <= isqrt(sqrt_n);
        end else if (sq_cnt != 0) begin
            sq_cnt <= sq_cnt - 1;
            if (sq_cnt == 1 && !stuck) sq_done <= 1'b1;
        end
    end

    // Bus monitor
    int         we_cnt = 0, st_cnt = 0, done_cnt = 0, st_double = 0, sqrtn_bad = 0;
    logic       prev_st = 1'b0;
    logic [3:0] wr_log [$];
    logic [3:0] rd_log [$];

    always @(posedge CLK) begin
        prev_st <= sqrt_st;
        if (ram_we) begin
            we_cnt <= we_cnt + 1;
            wr_log.push_back(ram_addr);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (sqrt_st) begin
            st_cnt <= st_cnt + 1;
            if (prev_st) st_double <= st_double + 1;
            if (sqrt_n !== mem[rd_addr_q]) sqrtn_bad <= sqrtn_bad + 1;
            rd_log.push_back(rd_addr_q);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge CLK);
        tb_we = 1'b0;
    endtask

    task automatic start(input logic [3:0] b, input logic [4:0] c);
        @(negedge CLK);
        base_addr = b; word_cnt = c; go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, we0, st0, dn0, wb, rb;
        ResetN = 1'b0; go = 1'b0; abort = 1'b0; base_addr = 4'd0; word_cnt = 5'd0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_proc_cnt", 32'(proc_cnt), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_sqrt_st", 32'(sqrt_st), 32'd0);
        check("rst_sqrt_n", 32'(sqrt_n), 32'd0);
        ResetN = 1'b1;
        for (int i = 0; i < 16; i++) poke(4'(i), 8'(8'h20 + i));

        // Basic 4-word batch
        poke(4'd0, 8'h00); poke(4'd1, 8'h01); poke(4'd2, 8'h51); poke(4'd3, 8'hFF);
        lat = 2;
        we0 = we_cnt; st0 = st_cnt; dn0 = done_cnt;
        start(4'd0, 5'd4);
        wait_done(200, cyc);
        check("t1_latency", 32'(cyc), 32'd32);
        @(negedge CLK);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_proc_cnt", 32'(proc_cnt), 32'd4);
        check("t1_err", 32'(err), 32'd0);
        check("t1_ram8", 32'(mem[8]), 32'h00);
        check("t1_ram9", 32'(mem[9]), 32'h01);
        check("t1_ram10", 32'(mem[10]), 32'h09);
        check("t1_ram11", 32'(mem[11]), 32'h0F);
        check("t1_writes", 32'(we_cnt - we0), 32'd4);
        check("t1_starts", 32'(st_cnt - st0), 32'd4);
        check("t1_done_cnt", 32'(done_cnt - dn0), 32'd1);

        // Address wrap
        poke(4'd14, 8'h10); poke(4'd15, 8'h24); poke(4'd0, 8'h40);
        lat = 1;
        we0 = we_cnt; wb = wr_log.size(); rb = rd_log.size();
        start(4'd14, 5'd3);
        wait_done(200, cyc);
        check("t2_latency", 32'(cyc), 32'd21);
        @(negedge CLK);
        check("t2_writes", 32'(we_cnt - we0), 32'd3);
        check("t2_rd0", 32'(rd_log[rb]), 32'd14);
        check("t2_rd1", 32'(rd_log[rb + 1]), 32'd15);
        check("t2_rd2", 32'(rd_log[rb + 2]), 32'd0);
        check("t2_wr0", 32'(wr_log[wb]), 32'd6);
        check("t2_wr1", 32'(wr_log[wb + 1]), 32'd7);
        check("t2_wr2", 32'(wr_log[wb + 2]), 32'd8);
        check("t2_ram6", 32'(mem[6]), 32'd4);
        check("t2_ram7", 32'(mem[7]), 32'd6);
        check("t2_ram8", 32'(mem[8]), 32'd8);

        // Zero count
        we0 = we_cnt; st0 = st_cnt;
        start(4'd5, 5'd0);
        check("t3_zero_busy", 32'(busy), 32'd1);
        check("t3_zero_done", 32'(done), 32'd1);
        @(negedge CLK);
        check("t3_zero_idle", 32'(busy), 32'd0);
        check("t3_zero_done_off", 32'(done), 32'd0);
        check("t3_zero_writes", 32'(we_cnt - we0), 32'd0);
        check("t3_zero_starts", 32'(st_cnt - st0), 32'd0);
        check("t3_zero_proc_cnt", 32'(proc_cnt), 32'd0);

        // Count clamp with overlapping result region
        for (int i = 0; i < 8; i++) poke(4'(i), 8'(i * i));
        lat = 1;
        we0 = we_cnt;
        start(4'd0, 5'd31);
        wait_done(400, cyc);
        check("t3_clamp_latency", 32'(cyc), 32'd112);
        @(negedge CLK);
        check("t3_clamp_proc_cnt", 32'(proc_cnt), 32'd16);
        check("t3_clamp_writes", 32'(we_cnt - we0), 32'd16);
        check("t3_clamp_ram13", 32'(mem[13]), 32'd5);
        check("t3_clamp_ram4", 32'(mem[4]), 32'd2);
        check("t3_clamp_ram7", 32'(mem[7]), 32'd2);
        check("t3_clamp_ram3", 32'(mem[3]), 32'd1);

        // Sqrt never finishes: timeout writes all-ones and batch carries on
        stuck = 1'b1;
        poke(4'd2, 8'h31); poke(4'd3, 8'h44);
        start(4'd2, 5'd2);
        wait_done(400, cyc);
        check("t4_latency", 32'(cyc), 32'd138);
        check("t4_err", 32'(err), 32'd1);
        @(negedge CLK);
        check("t4_proc_cnt", 32'(proc_cnt), 32'd2);
        check("t4_ram10", 32'(mem[10]), 32'hFF);
        check("t4_ram11", 32'(mem[11]), 32'hFF);
        check("t4_err_sticky", 32'(err), 32'd1);
        stuck = 1'b0; lat = 1;
        start(4'd2, 5'd1);
        check("t4_err_cleared", 32'(err), 32'd0);
        wait_done(100, cyc);
        @(negedge CLK);
        check("t4_ram10_ok", 32'(mem[10]), 32'd7);
        check("t4_err_clear_hold", 32'(err), 32'd0);

        // Abort in WT of the second word
        lat = 3;
        we0 = we_cnt; st0 = st_cnt; dn0 = done_cnt;
        start(4'd0, 5'd5);
        repeat (12) @(negedge CLK);
        check("t5_busy_pre_abort", 32'(busy), 32'd1);
        check("t5_starts_pre_abort", 32'(st_cnt - st0), 32'd2);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("t5_abort_idle", 32'(busy), 32'd0);
        check("t5_abort_no_done", 32'(done), 32'd0);
        check("t5_abort_proc_cnt", 32'(proc_cnt), 32'd1);
        repeat (20) @(negedge CLK);
        check("t5_abort_writes", 32'(we_cnt - we0), 32'd1);
        check("t5_abort_done_cnt", 32'(done_cnt - dn0), 32'd0);

        // Reset mid-batch
        poke(4'd0, 8'h90);
        lat = 1;
        start(4'd0, 5'd4);
        repeat (8) @(negedge CLK);
        check("t5_mid_proc_cnt", 32'(proc_cnt), 32'd1);
        check("t5_mid_sqrt_n", 32'(sqrt_n), 32'h90);
        check("t5_mid_ram_addr", 32'(ram_addr), 32'd1);
        ResetN = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_proc_cnt", 32'(proc_cnt), 32'd0);
        check("t5_rst_sqrt_n", 32'(sqrt_n), 32'd0);
        check("t5_rst_ram_addr", 32'(ram_addr), 32'd0);
        @(negedge CLK);
        ResetN = 1'b1;
        repeat (3) @(negedge CLK);
        check("t5_rst_stays_idle", 32'(busy), 32'd0);

        // go pulses while busy are ignored
        poke(4'd0, 8'h64); poke(4'd1, 8'h19);
        lat = 1;
        st0 = st_cnt; wb = wr_log.size(); dn0 = done_cnt;
        start(4'd0, 5'd2);
        base_addr = 4'd5; word_cnt = 5'd1; go = 1'b1;
        repeat (3) @(negedge CLK);
        go = 1'b0;
        wait_done(100, cyc);
        check("t6_latency", 32'(cyc + 3), 32'd14);
        @(negedge CLK);
        check("t6_proc_cnt", 32'(proc_cnt), 32'd2);
        check("t6_starts", 32'(st_cnt - st0), 32'd2);
        check("t6_wr0", 32'(wr_log[wb]), 32'd8);
        check("t6_wr1", 32'(wr_log[wb + 1]), 32'd9);
        check("t6_ram8", 32'(mem[8]), 32'd10);
        check("t6_ram9", 32'(mem[9]), 32'd5);
        check("t6_done_cnt", 32'(done_cnt - dn0), 32'd1);
        repeat (4) @(negedge CLK);
        check("t6_still_idle", 32'(busy), 32'd0);
        check("st_single_cycle", 32'(st_double), 32'd0);
        check("sqrt_n_matches_ram", 32'(sqrtn_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
